// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// datapath select codes and the Moore control word.
package mips_ctrl_pkg;

    localparam int OP_W = 6;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_EXECUTE = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_BRANCH  = 4'd8;
    localparam state_t S_ADDIEX  = 4'd9;
    localparam state_t S_ADDIWB  = 4'd10;
    localparam state_t S_JUMP    = 4'd11;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // pc_write_rdy / ir_write only take effect once memory reports ready
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_rdy;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state to control-word decode; unknown encodings give all zeros.
module main_fsm_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read     = 1'b1;
                ctrl.alu_src_b    = SRCB_FOUR;
                ctrl.ir_write     = 1'b1;
                ctrl.pc_write_rdy = 1'b1;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// MemReady/Zero gating applied on top of the Moore control word.
module multicycle_main_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            Zero,
    input  logic            MemReady,
    output logic [1:0]      ALUOp,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSrc,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            PCEn,
    output logic            IllegalOp
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   illegal;

    main_fsm_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    always_comb begin
        state_next = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_FETCH:   state_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            // Op is held by the instruction register, so it still selects lw/sw here
            S_MEMADR:  state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    assign ALUOp    = ctrl.alu_op;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSrc    = ctrl.pc_src;
    assign IorD     = ctrl.iord;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;

    // Reset kills every enable so an abandoned instruction writes nothing
    assign MemRead   = ~reset & ctrl.mem_read;
    assign MemWrite  = ~reset & ctrl.mem_write;
    assign IRWrite   = ~reset & ctrl.ir_write & MemReady;
    assign RegWrite  = ~reset & ctrl.reg_write;
    assign PCEn      = ~reset & (ctrl.pc_write | (ctrl.pc_write_rdy & MemReady)
                                 | (ctrl.branch & Zero));
    assign IllegalOp = ~reset & illegal;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed vector table, lw wait-state sequence and randomized run against a
// step-counting instruction model.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn, IllegalOp;
    logic [15:0] act;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn),
        .IllegalOp(IllegalOp)
    );

    assign act = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, PCEn, IllegalOp};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;
    // enable bits: MemRead, MemWrite, IRWrite, RegWrite, PCEn, IllegalOp
    localparam logic [15:0] EN_MASK = 16'h00E7;

    function automatic logic [15:0] ctl(input logic [1:0] aluop, input logic srca,
        input logic [1:0] srcb, input logic [1:0] pcsrc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic rd, input logic m2r, input logic rw,
        input logic pcen, input logic ill);
        return {aluop, srca, srcb, pcsrc, iord, mr, mw, irw, rd, m2r, rw, pcen, ill};
    endfunction

    // 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, -1 unsupported
    function automatic int op_class(input logic [5:0] op);
        case (op)
            R: return 0;  LW: return 1;  SW: return 2;
            BEQ: return 3;  ADDI: return 4;  J: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int last_step(input int cls);
        case (cls)
            1: return 4;
            3, 5: return 2;
            default: return 3;
        endcase
    endfunction

    // step = cycles into the instruction (0 fetch, 1 decode, ...); waits repeat a step
    function automatic logic [15:0] model_out(input int step, input int cls, input logic [5:0] op,
        input logic zero, input logic rdy, input logic rst);
        logic [15:0] v;
        v = '0;
        if (step == 0)      v = ctl(0, 0, 1, 0, 0, 1, 0, rdy, 0, 0, 0, rdy, 0);
        else if (step == 1) v = ctl(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, op_class(op) < 0);
        else if ((cls == 1 || cls == 2 || cls == 4) && step == 2)
                            v = ctl(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else if (cls == 1 && step == 3) v = ctl(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        else if (cls == 1 && step == 4) v = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        else if (cls == 2 && step == 3) v = ctl(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        else if (cls == 0 && step == 2) v = ctl(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else if (cls == 0 && step == 3) v = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        else if (cls == 3 && step == 2) v = ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, zero, 0);
        else if (cls == 4 && step == 3) v = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        else if (cls == 5 && step == 2) v = ctl(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (rst) v = v & ~EN_MASK;
        return v;
    endfunction

    task automatic check_vec(input string name, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic zero,
        input logic rdy, input logic [15:0] exp);
        vec_t r;
        r.rst = rst; r.op = op; r.zero = zero; r.rdy = rdy; r.exp = exp;
        return r;
    endfunction

    initial begin
        logic [15:0] f_rdy, f_wait, f_rst, dec, dec_ill, adr, rd_rst, wr, exe, aluwb;
        logic [15:0] br1, br0, jmp, addiwb;
        int step, cls, rw_cnt, rw_cyc, irw_cnt, irw_cyc, pcen_cnt;
        logic [5:0] r_op;
        logic [5:0] ops[6];

        f_rdy   = ctl(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        f_wait  = ctl(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        f_rst   = ctl(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec     = ctl(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec_ill = ctl(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        adr     = ctl(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd_rst  = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        wr      = ctl(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        exe     = ctl(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        aluwb   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        br1     = ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        br0     = ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        jmp     = ctl(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        addiwb  = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        tbl.push_back(mk(1, R, 0, 1, f_rst));    tbl.push_back(mk(1, R, 0, 1, f_rst));
        tbl.push_back(mk(0, R, 0, 1, f_rdy));    tbl.push_back(mk(0, R, 0, 0, dec));
        tbl.push_back(mk(0, R, 0, 1, exe));      tbl.push_back(mk(0, R, 0, 1, aluwb));
        tbl.push_back(mk(0, BEQ, 1, 1, f_rdy));  tbl.push_back(mk(0, BEQ, 1, 1, dec));
        tbl.push_back(mk(0, BEQ, 1, 0, br1));
        tbl.push_back(mk(0, BEQ, 0, 1, f_rdy));  tbl.push_back(mk(0, BEQ, 0, 1, dec));
        tbl.push_back(mk(0, BEQ, 0, 1, br0));
        tbl.push_back(mk(0, J, 0, 1, f_rdy));    tbl.push_back(mk(0, J, 0, 1, dec));
        tbl.push_back(mk(0, J, 0, 0, jmp));
        tbl.push_back(mk(0, ILL, 0, 1, f_rdy));  tbl.push_back(mk(0, ILL, 0, 1, dec_ill));
        tbl.push_back(mk(0, SW, 0, 1, f_rdy));   tbl.push_back(mk(0, SW, 0, 1, dec));
        tbl.push_back(mk(0, SW, 0, 0, adr));     tbl.push_back(mk(0, SW, 0, 0, wr));
        tbl.push_back(mk(0, SW, 0, 1, wr));
        tbl.push_back(mk(0, ADDI, 0, 0, f_wait)); tbl.push_back(mk(0, ADDI, 0, 1, f_rdy));
        tbl.push_back(mk(0, ADDI, 0, 0, dec));   tbl.push_back(mk(0, ADDI, 0, 1, adr));
        tbl.push_back(mk(0, ADDI, 0, 1, addiwb)); tbl.push_back(mk(0, ADDI, 0, 0, f_wait));
        tbl.push_back(mk(0, LW, 0, 1, f_rdy));   tbl.push_back(mk(0, LW, 0, 1, dec));
        tbl.push_back(mk(0, LW, 0, 1, adr));     tbl.push_back(mk(1, LW, 0, 1, rd_rst));
        tbl.push_back(mk(0, LW, 0, 0, f_wait));

        reset = 1'b1; Op = R; Zero = 1'b0; MemReady = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; Op = tbl[i].op; Zero = tbl[i].zero; MemReady = tbl[i].rdy;
            @(negedge clk);
            check_vec($sformatf("vec%0d", i), tbl[i].exp);
            @(posedge clk); #1;
        end

        // lw: FETCH waits 2 cycles, MEMRD waits 3; writeback lands on cycle 10
        reset = 1'b1; Op = LW; MemReady = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rw_cnt = 0; rw_cyc = 0; irw_cnt = 0; irw_cyc = 0; pcen_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            MemReady = !(c == 1 || c == 2 || (c >= 6 && c <= 8) || c >= 11);
            @(negedge clk);
            if (RegWrite && MemtoReg) begin rw_cnt++; rw_cyc = c; end
            if (IRWrite) begin irw_cnt++; irw_cyc = c; end
            if (PCEn) pcen_cnt++;
            @(posedge clk); #1;
        end
        check_int("lw_regwrite_count", rw_cnt, 1);
        check_int("lw_regwrite_cycle", rw_cyc, 10);
        check_int("lw_irwrite_count", irw_cnt, 1);
        check_int("lw_irwrite_cycle", irw_cyc, 3);
        check_int("lw_pcen_count", pcen_cnt, 1);

        ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = ADDI; ops[5] = J;
        step = 0; cls = 0; r_op = R;
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 0) || ($urandom_range(0, 49) == 0);
            if (step == 0)
                r_op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            Op = r_op; Zero = 1'($urandom_range(0, 1)); MemReady = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (i > 0) check_vec($sformatf("rand%0d", i), model_out(step, cls, Op, Zero, MemReady, reset));
            @(posedge clk);
            if (reset) step = 0;
            else if (step == 0) step = MemReady ? 1 : 0;
            else if (step == 1) begin
                cls = op_class(Op);
                step = (cls < 0) ? 0 : 2;
            end else if ((cls == 1 || cls == 2) && step == 3 && !MemReady) step = 3;
            else if (step == last_step(cls)) step = 0;
            else step++;
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
